// File: rtl/uart_wb_master_pkg.sv
// Shared command/reply codes and FSM state encoding for the uart-to-Wishbone debug bridge.
package uart_wb_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_OK  = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WB,
    ST_RESP,
    ST_SEND
  } state_t;

endpackage

// File: rtl/uart_wb_master.sv
// Debug bridge: parses uart byte packets into Wishbone reads/writes and sends replies back over the uart.
module uart_wb_master
  import uart_wb_master_pkg::*;
#(
  parameter int byte_timeout = 100000,
  parameter int wb_timeout   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam int BT_W = $clog2(byte_timeout + 1);
  localparam int WT_W = $clog2(wb_timeout + 1);

  state_t            state_reg;
  logic [1:0]        byte_idx_reg;
  logic [BT_W-1:0]   byte_timer_reg;
  logic [WT_W-1:0]   wb_timer_reg;
  logic              err_reg;
  logic [31:0]       tx_shift_reg;
  logic [2:0]        tx_left_reg;
  logic              rx_ack_reg;
  logic              tx_wr_reg;
  logic [7:0]        tx_data_reg;
  logic [31:0]       adr_reg;
  logic [31:0]       dat_reg;
  logic              we_reg;
  logic              cyc_reg;
  logic              rx_take;

  // Bytes are only consumed while parsing; the cycle after an ack is blind because avail is still falling.
  assign rx_take = rx_avail && !rx_ack_reg &&
                   (state_reg == ST_IDLE || state_reg == ST_ADDR || state_reg == ST_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      byte_idx_reg   <= '0;
      byte_timer_reg <= '0;
      wb_timer_reg   <= '0;
      err_reg        <= 1'b0;
      tx_shift_reg   <= '0;
      tx_left_reg    <= '0;
      rx_ack_reg     <= 1'b0;
      tx_wr_reg      <= 1'b0;
      tx_data_reg    <= '0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      we_reg         <= 1'b0;
      cyc_reg        <= 1'b0;
    end else begin
      rx_ack_reg <= rx_take;
      tx_wr_reg  <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (rx_take) begin
            byte_idx_reg   <= '0;
            byte_timer_reg <= '0;
            err_reg        <= 1'b0;
            if (rx_data == CMD_WR) begin
              we_reg    <= 1'b1;
              state_reg <= ST_ADDR;
            end else if (rx_data == CMD_RD) begin
              we_reg    <= 1'b0;
              state_reg <= ST_ADDR;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (rx_take) begin
            byte_timer_reg <= '0;
            byte_idx_reg   <= byte_idx_reg + 2'd1;
            if (state_reg == ST_ADDR) adr_reg <= {adr_reg[23:0], rx_data};
            else                      dat_reg <= {dat_reg[23:0], rx_data};
            if (byte_idx_reg == 2'd3) begin
              wb_timer_reg <= '0;
              if (state_reg == ST_ADDR && we_reg) begin
                state_reg <= ST_DATA;
              end else begin
                state_reg <= ST_WB;
                cyc_reg   <= 1'b1;
              end
            end
          end else if (byte_timer_reg == BT_W'(byte_timeout - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            byte_timer_reg <= byte_timer_reg + 1'b1;
          end
        end
        ST_WB: begin
          if (wb_ack_i) begin
            cyc_reg   <= 1'b0;
            state_reg <= ST_RESP;
            if (!we_reg) tx_shift_reg <= wb_dat_i;
          end else if (wb_timer_reg == WT_W'(wb_timeout - 1)) begin
            cyc_reg   <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            wb_timer_reg <= wb_timer_reg + 1'b1;
          end
        end
        ST_RESP: begin
          if (err_reg) begin
            tx_shift_reg <= {RSP_ERR, 24'h0};
            tx_left_reg  <= 3'd1;
          end else if (we_reg) begin
            tx_shift_reg <= {RSP_OK, 24'h0};
            tx_left_reg  <= 3'd1;
          end else begin
            tx_left_reg  <= 3'd4;
          end
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          // tx_busy is not yet valid in the cycle right after a write pulse.
          if (!tx_wr_reg && !tx_busy) begin
            tx_data_reg  <= tx_shift_reg[31:24];
            tx_shift_reg <= {tx_shift_reg[23:0], 8'h00};
            tx_wr_reg    <= 1'b1;
            tx_left_reg  <= tx_left_reg - 3'd1;
            if (tx_left_reg == 3'd1) state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rx_ack   = rx_ack_reg;
  assign tx_wr    = tx_wr_reg;
  assign tx_data  = tx_data_reg;
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;
  assign wb_we_o  = we_reg;
  assign wb_sel_o = 4'hF;
  assign wb_stb_o = cyc_reg;
  assign wb_cyc_o = cyc_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: uart byte model, Wishbone slave model and per-scenario tasks.
module tb_uart_wb_master;
  import uart_wb_master_pkg::*;

  localparam int BYTE_TO = 400;
  localparam int WB_TO   = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_avail = 1'b0;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        busy;

  uart_wb_master #(.byte_timeout(BYTE_TO), .wb_timeout(WB_TO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // uart transmitter model: records bytes, stays busy for a while after each write
  logic [7:0] tx_q[$];
  int busy_cnt = 0;
  int first_tx_n = -1;
  int tx_viol = 0;
  always @(negedge clk) begin
    if (tx_wr) begin
      if (tx_busy) tx_viol++;
      if (tx_q.size() == 0) first_tx_n = cyc_n;
      tx_q.push_back(tx_data);
      busy_cnt = 12;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt > 0);
  end

  // Wishbone slave model: acks two cycles into a cycle when enabled
  logic        ack_en = 1'b1;
  logic [31:0] rd_value = 32'h0;
  logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
  logic [3:0]  cap_sel = 4'h0;
  logic        cap_we = 1'b0, we_seen = 1'b0, cyc_after_ack = 1'b1;
  int wb_count = 0, cyc_cycles = 0, wait_cnt = 0, ack_n = -1;
  always @(negedge clk) begin
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      cyc_after_ack = wb_cyc_o | wb_stb_o;
    end else if (wb_cyc_o && wb_stb_o && ack_en) begin
      if (wait_cnt == 2) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rd_value;
        cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_we = wb_we_o; cap_sel = wb_sel_o;
        wb_count++;
        ack_n = cyc_n;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (wb_cyc_o) begin
      cyc_cycles++;
      if (wb_we_o) we_seen = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    @(negedge clk);
    rx_data = b;
    rx_avail = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rx_ack) got = 1;
    end
    rx_avail = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rx_ack byte=%02h: no ack within 50 cycles", b);
    end
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (cmd == CMD_WR)
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_q.size() < n) begin
      failures++;
      $display("FAIL %s: got %0d reply bytes, need %0d", name, tx_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic clear_mon();
    tx_q.delete();
    first_tx_n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_ack, tx_wr, tx_data, wb_we_o, wb_stb_o, wb_cyc_o, busy} !== 14'h0) begin
      failures++;
      $display("FAIL reset_ctrl: rx_ack=%b tx_wr=%b tx_data=%02h we=%b stb=%b cyc=%b busy=%b, need all 0",
               rx_ack, tx_wr, tx_data, wb_we_o, wb_stb_o, wb_cyc_o, busy);
    end
    checks++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: adr=%08h dat=%08h, need 0", wb_adr_o, wb_dat_o);
    end
    checks++;
    if (wb_sel_o !== 4'hF) begin
      failures++;
      $display("FAIL reset_sel: sel=%h, need F", wb_sel_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d, input string name);
    int n0 = wb_count;
    clear_mon();
    send_pkt(CMD_WR, a, d);
    wait_tx(1, 2000, name);
    wait_idle(2000);
    checks++;
    if (wb_count !== n0 + 1) begin
      failures++;
      $display("FAIL %s_count: %0d wb cycles, need 1", name, wb_count - n0);
    end
    checks++;
    if (cap_adr !== a || cap_dat !== d || cap_we !== 1'b1 || cap_sel !== 4'hF) begin
      failures++;
      $display("FAIL %s_bus: adr=%08h dat=%08h we=%b sel=%h, need %08h %08h 1 F",
               name, cap_adr, cap_dat, cap_we, cap_sel, a, d);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== RSP_OK) begin
      failures++;
      $display("FAIL %s_reply: %0d bytes first=%02h, need 1 byte AA", name, tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
    $display("write adr=%08h dat=%08h reply_bytes=%0d", a, d, tx_q.size());
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] v, input string name);
    logic [7:0] exp_b;
    clear_mon();
    rd_value = v;
    we_seen = 1'b0;
    cyc_after_ack = 1'b1;
    send_pkt(CMD_RD, a, 32'h0);
    wait_tx(4, 2000, name);
    wait_idle(2000);
    checks++;
    if (cap_adr !== a || cap_we !== 1'b0 || we_seen !== 1'b0) begin
      failures++;
      $display("FAIL %s_bus: adr=%08h we=%b we_seen=%b, need %08h 0 0", name, cap_adr, cap_we, we_seen, a);
    end
    checks++;
    if (tx_q.size() != 4) begin
      failures++;
      $display("FAIL %s_len: %0d reply bytes, need 4", name, tx_q.size());
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      exp_b = v[8*(3-i) +: 8];
      checks++;
      if (tx_q[i] !== exp_b) begin
        failures++;
        $display("FAIL %s_byte%0d: got %02h, need %02h", name, i, tx_q[i], exp_b);
      end
    end
    checks++;
    if (cyc_after_ack !== 1'b0 || first_tx_n - (ack_n + 1) < 2) begin
      failures++;
      $display("FAIL %s_latency: cyc_after_ack=%b first_tx_delay=%0d, need 0 and >=2",
               name, cyc_after_ack, first_tx_n - (ack_n + 1));
    end
    checks++;
    if (tx_viol != 0) begin
      failures++;
      $display("FAIL %s_txbusy: %0d writes while busy, need 0", name, tx_viol);
    end
    $display("read adr=%08h value=%08h reply_bytes=%0d", a, v, tx_q.size());
  endtask

  task automatic test_wb_timeout();
    clear_mon();
    ack_en = 1'b0;
    cyc_cycles = 0;
    send_pkt(CMD_RD, 32'h0000DEAD, 32'h0);
    wait_tx(1, 2000, "wb_timeout");
    wait_idle(2000);
    checks++;
    if (cyc_cycles != WB_TO) begin
      failures++;
      $display("FAIL wb_timeout_len: cyc high %0d cycles, need %0d", cyc_cycles, WB_TO);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== RSP_ERR || busy !== 1'b0) begin
      failures++;
      $display("FAIL wb_timeout_reply: %0d bytes first=%02h busy=%b, need 1 byte EE busy 0",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, busy);
    end
    ack_en = 1'b1;
    $display("wb_timeout cyc_cycles=%0d reply_bytes=%0d", cyc_cycles, tx_q.size());
  endtask

  task automatic test_byte_timeout();
    int n0 = wb_count;
    clear_mon();
    send_byte(CMD_WR);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (BYTE_TO + 50) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wb_count != n0 || tx_q.size() != 0 || wb_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL byte_timeout: busy=%b wb=%0d replies=%0d cyc=%b, need 0 0 0 0",
               busy, wb_count - n0, tx_q.size(), wb_cyc_o);
    end
    $display("byte_timeout busy=%b replies=%0d", busy, tx_q.size());
    test_read(32'h00002000, 32'hCAFEF00D, "read_after_to");
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_cmd: busy=%b, need 0", busy);
    end
    $display("bad_cmd 55 busy=%b", busy);
    test_read(32'h00000004, 32'h0BADF00D, "read_after_bad");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_mon();
    ack_en = 1'b0;
    send_pkt(CMD_RD, 32'h00003000, 32'h0);
    while (!wb_cyc_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_start: cyc=%b, need 1", wb_cyc_o);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || tx_wr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: cyc=%b stb=%b tx_wr=%b busy=%b, need 0", wb_cyc_o, wb_stb_o, tx_wr, busy);
    end
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (tx_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_reply: %0d reply bytes, need 0", tx_q.size());
    end
    $display("reset_mid replies=%0d", tx_q.size());
    test_write(32'h00000010, 32'h01020304, "write_after_rst");
  endtask

  initial begin
    test_reset();
    test_write(32'h00001000, 32'hDEADBEEF, "write");
    test_read(32'h00001000, 32'h12345678, "read");
    test_wb_timeout();
    test_byte_timeout();
    test_bad_cmd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
